reg_status_table: RTL
=====================

REG_STATUS_TABLE -- requirements
Module: reg_status_table

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers tracked (entry 0 hard-wired not pending).
REQ-002 Parameter TAG_W, default 6, tag width, matching the free-tag FIFO and CDB tag width.
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rs1_addr  input  5  source 1 register index for lookup.
REQ-006 rs2_addr  input  5  source 2 register index for lookup.
REQ-007 rs1_pending  output  1  source 1 awaits a producer tag.
REQ-008 rs1_tag  output  TAG_W  producer tag for source 1, valid when rs1_pending=1.
REQ-009 rs2_pending  output  1  source 2 awaits a producer tag.
REQ-010 rs2_tag  output  TAG_W  producer tag for source 2, valid when rs2_pending=1.
REQ-011 dispatch_en  input  1  instruction with destination dispatching this cycle.
REQ-012 dispatch_rd  input  5  destination register index.
REQ-013 free_tag  input  TAG_W  head of free-tag FIFO (FIFO tag_out).
REQ-014 free_empty  input  1  free-tag FIFO empty (FIFO fifo_empty).
REQ-015 tag_pull  output  1  pop request to free-tag FIFO (FIFO tag_pull).
REQ-016 dispatch_stall  output  1  dispatch blocked, no free tag.
REQ-017 cdb_valid  input  1  CDB broadcast valid.
REQ-018 cdb_tag  input  TAG_W  tag being broadcast on CDB.
REQ-019 busy_count  output  6  number of entries currently pending.

Function
REQ-020 Each entry SHALL hold a pending bit and a TAG_W tag; entry 0 SHALL never become pending.
REQ-021 Lookup SHALL be combinational: rsN_pending = entry pending AND NOT (cdb_valid AND cdb_tag == entry tag); rsN_tag = entry tag.
REQ-022 Lookup SHALL reflect state before any same-cycle dispatch write, so the instruction's own destination never affects its sources.
REQ-023 Allocation occurs when dispatch_en=1, dispatch_rd!=0 and free_empty=0; tag_pull SHALL be asserted combinationally in that cycle only.
REQ-024 On allocation, entry[dispatch_rd] SHALL become pending with tag free_tag at the next rising edge.
REQ-025 dispatch_stall SHALL equal dispatch_en AND dispatch_rd!=0 AND free_empty; on stall no entry changes and tag_pull=0.
REQ-026 dispatch_rd=0 with dispatch_en=1 SHALL neither allocate nor stall; tag_pull=0.
REQ-027 On cdb_valid=1, every pending entry whose tag equals cdb_tag SHALL clear its pending bit at the next edge; the tag field keeps its value.
REQ-028 Same-cycle allocation and CDB clear on the same entry: allocation SHALL win (entry pending with free_tag).
REQ-029 Allocation to an already-pending entry SHALL overwrite its tag; the old tag is not returned by this block.
REQ-030 busy_count SHALL be +1 per allocation to a non-pending entry, -1 per CDB clear of an entry not overwritten in the same cycle, net 0 otherwise; never exceeds NUM_REGS-1 nor underflows.
REQ-031 cdb_tag matching no pending entry SHALL leave all state unchanged.

Reset
REQ-032 On rst=1, asynchronously: all pending bits 0, all tags 0, busy_count 0; hence rs1_pending=rs2_pending=0 and tag_pull/dispatch_stall follow inputs only.
REQ-033 Reset asserted mid-operation SHALL discard all pending state regardless of same-cycle dispatch or CDB inputs.

Verification
REQ-034 Reset, then dispatch_en=1, rd=5, free_tag=0, free_empty=0 -> tag_pull=1 that cycle; next cycle rs1_addr=5 gives rs1_pending=1, rs1_tag=0, busy_count=1.
REQ-035 Entry 5 pending tag 0; cdb_valid=1, cdb_tag=0 -> same-cycle rs1_pending=0 (bypass); next cycle entry 5 not pending, busy_count=0.
REQ-036 Entry 5 pending tag 3; dispatch rd=5 with free_tag=9 and cdb_tag=3 same cycle -> entry 5 pending tag 9, busy_count unchanged at 1.
REQ-037 free_empty=1, dispatch_en=1, rd=7 -> dispatch_stall=1, tag_pull=0, entry 7 and busy_count unchanged; rd=0 -> stall=0, tag_pull=0.
REQ-038 Fill regs 1..31 with tags 0..30 -> busy_count=31; assert rst mid-cycle -> immediately all pending 0, busy_count 0.
REQ-039 rs1_addr=rs2_addr=rd=4 dispatching with entry 4 not pending -> rs1_pending=rs2_pending=0 that cycle, 1 the next.

Source files
------------

// File: rtl/reg_status_table.sv
// Register status table: tracks, per architectural register, whether it awaits a
// producer tag and which tag, with CDB bypass on lookup and free-tag allocation.
module reg_status_table #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_pending,
  output logic [TAG_W-1:0] rs1_tag,
  output logic             rs2_pending,
  output logic [TAG_W-1:0] rs2_tag,
  input  logic             dispatch_en,
  input  logic [4:0]       dispatch_rd,
  input  logic [TAG_W-1:0] free_tag,
  input  logic             free_empty,
  output logic             tag_pull,
  output logic             dispatch_stall,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic [5:0]       busy_count
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;
  logic [TAG_W-1:0]    tags [NUM_REGS];
  logic [5:0]          busy_next;
  logic                rd_valid;
  logic                alloc;

  assign rd_valid       = dispatch_en && (dispatch_rd != 5'd0) && (int'(dispatch_rd) < NUM_REGS);
  assign alloc          = rd_valid && !free_empty;
  assign tag_pull       = alloc;
  assign dispatch_stall = rd_valid && free_empty;

  // Lookups read the pre-dispatch state; a matching CDB broadcast is bypassed so
  // the consumer sees the value as already produced.
  always_comb begin
    rs1_pending = 1'b0;
    rs1_tag     = '0;
    if (int'(rs1_addr) < NUM_REGS) begin
      rs1_tag     = tags[rs1_addr];
      rs1_pending = pending[rs1_addr] && !(cdb_valid && (cdb_tag == tags[rs1_addr]));
    end
  end

  always_comb begin
    rs2_pending = 1'b0;
    rs2_tag     = '0;
    if (int'(rs2_addr) < NUM_REGS) begin
      rs2_tag     = tags[rs2_addr];
      rs2_pending = pending[rs2_addr] && !(cdb_valid && (cdb_tag == tags[rs2_addr]));
    end
  end

  // CDB clears first, then allocation overrides so a same-entry collision stays pending.
  always_comb begin
    pending_next = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      pending_next[i] = pending[i] && !(cdb_valid && (cdb_tag == tags[i]));
      if (alloc && (dispatch_rd == 5'(i)))
        pending_next[i] = 1'b1;
    end
  end

  // Busy count is the population of the next pending vector, so it can never drift.
  always_comb begin
    busy_next = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_next = busy_next + 6'(pending_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      busy_count <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        tags[i] <= '0;
    end else begin
      pending    <= pending_next;
      busy_count <= busy_next;
      if (alloc)
        tags[dispatch_rd] <= free_tag;
    end
  end

endmodule
